// File: rtl/uart_tx_feeder.sv
// Byte FIFO plus launch sequencer feeding a UART transmitter: buffers bytes,
// presents them one at a time with a registered one-cycle tx_Start pulse.
module uart_tx_feeder #(
    parameter int ADDR_W     = 4,
    parameter int GAP_CYCLES = 0
) (
    input  logic              sample_Clk,
    input  logic              reset,
    input  logic [7:0]        wr_Data,
    input  logic              wr_En,
    input  logic              tx_Done,
    output logic [7:0]        tx_Data,
    output logic              tx_Start,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              overflow
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [7:0] GAP_LOAD = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

    typedef enum logic [1:0] {IDLE, PULSE, WAIT, GAP} state_e;

    state_e              state_q, state_d;
    logic [7:0]          mem [DEPTH];
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                full_q, empty_q;
    logic                overflow_q, overflow_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic                tx_start_q, tx_start_d;
    logic [7:0]          gap_q, gap_d;
    logic                wr_acc;
    logic                pop;

    // Storage has no reset: a reset discards contents by clearing the pointers.
    always_ff @(posedge sample_Clk) begin
        if (wr_acc) begin
            mem[wr_ptr_q] <= wr_Data;
        end
    end

    always_comb begin
        wr_acc     = wr_En && !full_q;
        wr_ptr_d   = wr_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
        overflow_d = overflow_q | (wr_En & full_q);
        unique case ({wr_acc, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        rd_ptr_d   = rd_ptr_q;
        gap_d      = gap_q;
        pop        = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty_q && tx_Done) begin
                    pop        = 1'b1;
                    tx_data_d  = mem[rd_ptr_q];
                    rd_ptr_d   = rd_ptr_q + 1'b1;
                    tx_start_d = 1'b1;
                    state_d    = PULSE;
                end
            end
            PULSE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (tx_Done) begin
                    if (GAP_CYCLES > 0) begin
                        state_d = GAP;
                        gap_d   = GAP_LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge sample_Clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
            tx_data_q  <= 8'd0;
            tx_start_q <= 1'b0;
            gap_q      <= 8'd0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= (count_d == DEPTH_CNT);
            empty_q    <= (count_d == '0);
            overflow_q <= overflow_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            gap_q      <= gap_d;
        end
    end

    assign tx_Data  = tx_data_q;
    assign tx_Start = tx_start_q;
    assign full     = full_q;
    assign empty    = empty_q;
    assign count    = count_q;
    assign busy     = (state_q != IDLE);
    assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Scoreboard bench for uart_tx_feeder: two instances (no gap and a 5-cycle gap),
// each paired with a simple transmitter model that holds tx_Done low for 10 cycles.
module tb_uart_tx_feeder;

    logic       sampleClk = 1'b0;
    logic       reset;
    logic [7:0] wrData, wrData5;
    logic       wrEn, wrEn5;
    logic       hold;
    logic       txDone, txDone5;
    logic [7:0] txData, txData5;
    logic       txStart, txStart5;
    logic       full, empty, busy, overflow;
    logic       full5, empty5, busy5, overflow5;
    logic [4:0] count, count5;

    int checks = 0;
    int errors = 0;
    int cycle = 0;
    int pulseCount = 0;
    int prevCycle = 0;
    bit havePrev = 1'b0;
    bit spacingOn = 1'b0;
    int maxCount = 0;
    int pulses5 = 0;
    int prev5 = 0;
    int busyCnt5 = 0;

    logic [7:0] expQ[$];
    logic [7:0] expQ5[$];

    logic txIdle = 1'b1;
    int   txCnt = 0;
    logic txIdle5 = 1'b1;
    int   txCnt5 = 0;

    uart_tx_feeder #(.ADDR_W(4), .GAP_CYCLES(0)) dut (
        .sample_Clk(sampleClk), .reset(reset), .wr_Data(wrData), .wr_En(wrEn),
        .tx_Done(txDone), .tx_Data(txData), .tx_Start(txStart), .full(full),
        .empty(empty), .count(count), .busy(busy), .overflow(overflow)
    );

    uart_tx_feeder #(.ADDR_W(4), .GAP_CYCLES(5)) dutGap (
        .sample_Clk(sampleClk), .reset(reset), .wr_Data(wrData5), .wr_En(wrEn5),
        .tx_Done(txDone5), .tx_Data(txData5), .tx_Start(txStart5), .full(full5),
        .empty(empty5), .count(count5), .busy(busy5), .overflow(overflow5)
    );

    always #5 sampleClk = ~sampleClk;

    always @(posedge sampleClk) cycle <= cycle + 1;

    // Transmitter models: latch on tx_Start while idle, then busy for 10 cycles.
    assign txDone  = txIdle && !hold;
    assign txDone5 = txIdle5;

    always @(posedge sampleClk) begin
        if (txStart && txDone) begin
            txIdle <= 1'b0;
            txCnt  <= 10;
        end else if (txCnt > 1) begin
            txCnt <= txCnt - 1;
        end else if (txCnt == 1) begin
            txCnt  <= 0;
            txIdle <= 1'b1;
        end
    end

    always @(posedge sampleClk) begin
        if (txStart5 && txDone5) begin
            txIdle5 <= 1'b0;
            txCnt5  <= 10;
        end else if (txCnt5 > 1) begin
            txCnt5 <= txCnt5 - 1;
        end else if (txCnt5 == 1) begin
            txCnt5  <= 0;
            txIdle5 <= 1'b1;
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at cycle %0d", name, actual, expected, cycle);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b, input bit expectAccept);
        wrData = b;
        wrEn   = 1'b1;
        if (expectAccept) expQ.push_back(b);
        @(posedge sampleClk);
        #1;
        wrEn = 1'b0;
    endtask

    task automatic waitDrain(input int budget, input string name);
        int n = 0;
        while ((expQ.size() != 0 || busy) && n < budget) begin
            @(posedge sampleClk);
            #1;
            n++;
        end
        checkOutput(name, int'(n >= budget), 0);
    endtask

    // Monitor for the no-gap instance: every launch must match the scoreboard head.
    always @(negedge sampleClk) begin
        if (!reset && txStart) begin
            pulseCount++;
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_start actual=%0h expected=none at cycle %0d", txData, cycle);
            end else begin
                checkOutput("tx_data", txData, expQ.pop_front());
            end
            if (spacingOn && havePrev) checkOutput("start_spacing", cycle - prevCycle, 13);
            prevCycle = cycle;
            havePrev  = 1'b1;
        end
        if (int'(count) > maxCount) maxCount = count;
    end

    always @(negedge sampleClk) begin
        if (!reset && txStart5) begin
            pulses5++;
            if (expQ5.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_start_gap actual=%0h expected=none", txData5);
            end else begin
                checkOutput("tx_data_gap", txData5, expQ5.pop_front());
            end
            if (pulses5 == 2) checkOutput("gap_spacing", cycle - prev5, 18);
            prev5 = cycle;
        end
        if (pulses5 == 1 && busy5) busyCnt5++;
    end

    initial begin
        int n;
        int startPulses;
        reset   = 1'b1;
        wrEn    = 1'b0;
        wrData  = 8'h00;
        wrEn5   = 1'b0;
        wrData5 = 8'h00;
        hold    = 1'b0;
        repeat (3) @(posedge sampleClk);
        #1;
        checkOutput("rst_tx_start", txStart, 0);
        checkOutput("rst_tx_data", txData, 0);
        checkOutput("rst_count", count, 0);
        checkOutput("rst_empty", empty, 1);
        checkOutput("rst_full", full, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_overflow", overflow, 0);
        reset = 1'b0;
        @(posedge sampleClk);
        #1;

        $display("[TB] single byte");
        applyStimulus(8'hA5, 1'b1);
        checkOutput("single_start_E0", txStart, 0);
        checkOutput("single_count_E0", count, 1);
        checkOutput("single_empty_E0", empty, 0);
        @(posedge sampleClk);
        #1;
        checkOutput("single_start_E1", txStart, 1);
        checkOutput("single_data_E1", txData, 8'hA5);
        checkOutput("single_empty_E1", empty, 1);
        checkOutput("single_busy_E1", busy, 1);
        n = 0;
        while (busy && n < 100) begin
            @(posedge sampleClk);
            #1;
            n++;
        end
        // PULSE plus 11 WAIT cycles before tx_Done is seen high again.
        checkOutput("single_busy_len", n, 12);

        $display("[TB] burst order");
        maxCount  = 0;
        havePrev  = 1'b0;
        spacingOn = 1'b1;
        for (int i = 0; i < 16; i++) applyStimulus(8'(i), 1'b1);
        waitDrain(400, "burst_drain_timeout");
        spacingOn = 1'b0;
        // 16 writes on E0..E15 against pops on E1 and E14 leave a peak of 14.
        checkOutput("burst_peak_count", maxCount, 14);
        checkOutput("burst_overflow", overflow, 0);

        $display("[TB] overflow");
        hold = 1'b1;
        for (int i = 0; i < 17; i++) begin
            applyStimulus(8'(8'h10 + i), i < 16);
            if (i == 15) begin
                checkOutput("ovf_full_16", full, 1);
                checkOutput("ovf_count_16", count, 16);
                checkOutput("ovf_flag_16", overflow, 0);
            end
        end
        checkOutput("ovf_flag_17", overflow, 1);
        checkOutput("ovf_count_17", count, 16);
        startPulses = pulseCount;
        hold = 1'b0;
        waitDrain(400, "ovf_drain_timeout");
        checkOutput("ovf_bytes_out", pulseCount - startPulses, 16);
        checkOutput("ovf_sticky", overflow, 1);
        checkOutput("ovf_empty", empty, 1);

        $display("[TB] full with simultaneous pop");
        hold = 1'b1;
        for (int i = 0; i < 16; i++) applyStimulus(8'(8'h40 + i), 1'b1);
        checkOutput("fsp_full", full, 1);
        hold   = 1'b0;
        wrData = 8'h5A;
        wrEn   = 1'b1;
        @(posedge sampleClk);
        #1;
        wrEn = 1'b0;
        checkOutput("fsp_start", txStart, 1);
        checkOutput("fsp_count_15", count, 15);
        checkOutput("fsp_full_0", full, 0);
        applyStimulus(8'h77, 1'b1);
        checkOutput("fsp_count_16", count, 16);
        checkOutput("fsp_full_1", full, 1);
        waitDrain(400, "fsp_drain_timeout");
        checkOutput("fsp_empty", empty, 1);

        $display("[TB] reset mid-frame");
        hold = 1'b1;
        for (int i = 0; i < 4; i++) applyStimulus(8'(8'h60 + i), i == 0);
        hold = 1'b0;
        repeat (3) @(posedge sampleClk);
        #2;
        checkOutput("mid_busy_before", busy, 1);
        checkOutput("mid_count_before", count, 3);
        reset = 1'b1;
        #1;
        checkOutput("mid_tx_start", txStart, 0);
        checkOutput("mid_count", count, 0);
        checkOutput("mid_empty", empty, 1);
        checkOutput("mid_overflow", overflow, 0);
        checkOutput("mid_busy", busy, 0);
        repeat (2) @(posedge sampleClk);
        #1;
        reset = 1'b0;
        startPulses = pulseCount;
        repeat (40) @(posedge sampleClk);
        #1;
        checkOutput("mid_no_relaunch", pulseCount - startPulses, 0);
        checkOutput("mid_count_after", count, 0);

        $display("[TB] gap");
        wrData5 = 8'hC3;
        wrEn5   = 1'b1;
        expQ5.push_back(8'hC3);
        @(posedge sampleClk);
        #1;
        wrData5 = 8'h3C;
        expQ5.push_back(8'h3C);
        @(posedge sampleClk);
        #1;
        wrEn5 = 1'b0;
        n = 0;
        while ((pulses5 < 2 || busy5) && n < 200) begin
            @(posedge sampleClk);
            #1;
            n++;
        end
        checkOutput("gap_timeout", int'(n >= 200), 0);
        checkOutput("gap_pulses", pulses5, 2);
        // PULSE + 11 WAIT + 5 GAP cycles stay busy; only the single IDLE cycle is not.
        checkOutput("gap_busy_cycles", busyCnt5, 17);
        checkOutput("gap_empty", empty5, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
